// File: rtl/sq_accum.sv
// sq_accum: pipelined pixel squarer with an optional window sum-of-squares.
// Stage 1 registers pixel*pixel; stage 2 either emits the square directly
// (mode 0) or folds it into an accumulator and emits the total after ACC_N
// accepted pixels (mode 1). Ready/valid handshakes on both sides.

module sq_accum #(
  parameter  int PIX_W = 8,
  parameter  int ACC_N = 16,
  localparam int CNT_W = $clog2(ACC_N),
  localparam int ACC_W = 2 * PIX_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int              SQ_W     = 2 * PIX_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_N - 1);

  // Stage 1 state
  logic             r_s1_v;
  logic [SQ_W-1:0]  r_sq;

  // Stage 2 / window state
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_win_cnt;
  logic             r_mode;

  // Output register
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;

  // Combinational helpers
  logic             w_adv;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_win_start;
  logic             w_win_end;
  logic             w_mode_eff;
  logic             w_emit;
  logic [SQ_W-1:0]  w_sq;
  logic [ACC_W-1:0] w_sq_ext;
  logic [ACC_W-1:0] w_sum;

  // Exact full-width square; both operands widened so no bits are lost.
  assign w_sq = {{PIX_W{1'b0}}, pixel} * {{PIX_W{1'b0}}, pixel};

  // Stage 2 moves when it holds data and the output register is free or draining.
  assign w_adv      = r_s1_v & (~r_out_valid | out_ready);
  assign w_out_fire = r_out_valid & out_ready;

  // Clear blocks intake for its cycle; while in reset the block reports ready.
  assign in_ready  = ~rst_n | (~clear & (~r_s1_v | w_adv));
  assign w_in_fire = in_valid & in_ready;

  // Mode is live only at a window boundary; inside a window the latched copy rules.
  assign w_win_start = (r_win_cnt == '0);
  assign w_win_end   = (r_win_cnt == LAST_CNT);
  assign w_mode_eff  = w_win_start ? mode : r_mode;

  // A result is produced for every square in mode 0, and on the last pixel in mode 1.
  assign w_emit = w_adv & (~w_mode_eff | w_win_end);

  assign w_sq_ext = {{CNT_W{1'b0}}, r_sq};
  assign w_sum    = r_acc + w_sq_ext;

  // Stage 1: capture the square of each accepted pixel, drop it once stage 2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_sq   <= '0;
    end else if (clear) begin
      r_s1_v <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_v <= 1'b1;
      r_sq   <= w_sq;
    end else if (w_adv) begin
      r_s1_v <= 1'b0;
    end
  end

  // Latch the mode while no window is open so a mid-window change waits its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (w_win_start) begin
      r_mode <= mode;
    end
  end

  // Window accumulator and pixel counter; the final pixel resets the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_win_cnt <= '0;
    end else if (clear) begin
      r_acc     <= '0;
      r_win_cnt <= '0;
    end else if (w_adv && w_mode_eff) begin
      if (w_win_end) begin
        r_win_cnt <= '0;
      end else begin
        r_acc     <= w_win_start ? w_sq_ext : w_sum;
        r_win_cnt <= r_win_cnt + 1'b1;
      end
    end
  end

  // Output register: load a new result, otherwise retire the current one on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_data  <= w_mode_eff ? w_sum : w_sq_ext;
      r_out_valid <= 1'b1;
      r_out_last  <= 1'b1;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_s1_v | (r_win_cnt != '0);

endmodule

// File: tb/tb_sq_accum.sv
// Self-checking bench for sq_accum: directed scenarios plus a randomized
// stream scored against a window-level reference model.

module tb_sq_accum;

  localparam int PIX_W = 8;
  localparam int ACC_N = 16;
  localparam int ACC_W = 2 * PIX_W + $clog2(ACC_N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] pixel;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_last;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Reference model state and scoreboards
  longint exp_data_q[$];
  int     exp_cyc_q[$];
  longint obs_data_q[$];
  bit     obs_last_q[$];
  int     obs_cyc_q[$];
  int     cyc = 0;
  int     m_cnt = 0;
  longint m_sum = 0;
  bit     m_mode = 1'b0;

  sq_accum #(.PIX_W(PIX_W), .ACC_N(ACC_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel     (pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: records accepted pixels into the model and completed outputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data_q.delete();
      exp_cyc_q.delete();
      obs_data_q.delete();
      obs_last_q.delete();
      obs_cyc_q.delete();
      m_cnt = 0;
      m_sum = 0;
    end else begin
      if (out_valid && out_ready) begin
        obs_data_q.push_back(longint'(out_data));
        obs_last_q.push_back(out_last);
        obs_cyc_q.push_back(cyc);
      end
      if (clear) begin
        m_cnt = 0;
        m_sum = 0;
      end else if (in_valid && in_ready) begin
        longint sq;
        sq = longint'(pixel) * longint'(pixel);
        if (m_cnt == 0) m_mode = mode;
        if (!m_mode) begin
          exp_data_q.push_back(sq);
          exp_cyc_q.push_back(cyc + 2);
        end else begin
          m_sum += sq;
          m_cnt++;
          if (m_cnt == ACC_N) begin
            exp_data_q.push_back(m_sum);
            exp_cyc_q.push_back(cyc + 2);
            m_cnt = 0;
            m_sum = 0;
          end
        end
      end
    end
    cyc++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_queues();
    exp_data_q.delete();
    exp_cyc_q.delete();
    obs_data_q.delete();
    obs_last_q.delete();
    obs_cyc_q.delete();
  endtask

  // Present one pixel until accepted; leaves in_valid high for back-to-back use.
  task automatic send_pixel(input logic [PIX_W-1:0] p);
    int n;
    bit ok;
    pixel    = p;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_pixel: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  // Wait until the pipeline and output register are empty (out_ready held 1).
  task automatic wait_drain();
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      done = !busy && !out_valid;
      n++;
    end
    tick();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain: busy=%0b out_valid=%0b after %0d cycles, required 0/0", busy, out_valid, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pixel = '0;
    #3 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b required 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %0b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %0b required 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %0b required 0", busy); end
    flush_queues();
    $display("test_reset done");
  endtask

  task automatic test_mode0_basic();
    int     px[4]   = '{0, 1, 255, 128};
    longint expv[4] = '{0, 1, 65025, 16384};
    mode = 1'b0; out_ready = 1'b1;
    flush_queues();
    for (int i = 0; i < 4; i++) send_pixel(PIX_W'(px[i]));
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (obs_data_q.size() !== 4) begin
      errors++; $display("FAIL m0_count: got %0d outputs required 4", obs_data_q.size());
    end
    for (int i = 0; i < 4 && i < obs_data_q.size(); i++) begin
      checks++; if (obs_data_q[i] !== expv[i]) begin errors++; $display("FAIL m0_data[%0d]: got %0d required %0d", i, obs_data_q[i], expv[i]); end
      checks++; if (obs_last_q[i] !== 1'b1) begin errors++; $display("FAIL m0_last[%0d]: got %0b required 1", i, obs_last_q[i]); end
      if (i < exp_cyc_q.size()) begin
        checks++; if (obs_cyc_q[i] !== exp_cyc_q[i]) begin errors++; $display("FAIL m0_latency[%0d]: out at cycle %0d required %0d", i, obs_cyc_q[i], exp_cyc_q[i]); end
      end
      $display("mode0 pixel=%0d out=%0d last=%0b", px[i], obs_data_q[i], obs_last_q[i]);
    end
  endtask

  task automatic test_window_sum();
    mode = 1'b1; out_ready = 1'b1;
    flush_queues();
    for (int i = 0; i < ACC_N; i++) send_pixel(PIX_W'(255));
    in_valid = 1'b0;
    wait_drain();
    mode = 1'b0;
    checks++;
    if (obs_data_q.size() !== 1) begin
      errors++; $display("FAIL win_count: got %0d outputs required 1", obs_data_q.size());
    end else begin
      checks++; if (obs_data_q[0] !== 64'd1040400) begin errors++; $display("FAIL win_data: got %0d required 1040400", obs_data_q[0]); end
      checks++; if (obs_last_q[0] !== 1'b1) begin errors++; $display("FAIL win_last: got %0b required 1", obs_last_q[0]); end
      checks++; if (obs_cyc_q[0] !== exp_cyc_q[0]) begin errors++; $display("FAIL win_latency: cycle %0d required %0d", obs_cyc_q[0], exp_cyc_q[0]); end
      $display("window sum of 16x255 out=%0d", obs_data_q[0]);
    end
  endtask

  task automatic test_backpressure();
    int     px[8];
    int     idx = 0;
    int     accepts = 0;
    bit     acc;
    longint held;
    for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(1, 255));
    held = longint'(px[0]) * px[0];
    mode = 1'b0;
    flush_queues();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pixel = PIX_W'(px[idx]); in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (c >= 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %0b required 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c%0d: got %0b required 1", c, out_valid); end
        checks++; if (longint'(out_data) !== held) begin errors++; $display("FAIL bp_hold c%0d: got %0d required %0d", c, out_data, held); end
      end
      @(posedge clk); #1;
      if (acc) begin idx++; accepts++; end
    end
    checks++; if (accepts !== 2) begin errors++; $display("FAIL bp_accepts: got %0d required 2", accepts); end
    out_ready = 1'b1;
    while (idx < 8) begin send_pixel(PIX_W'(px[idx])); idx++; end
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (obs_data_q.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d outputs required 8", obs_data_q.size()); end
    for (int i = 0; i < 8 && i < obs_data_q.size(); i++) begin
      checks++;
      if (obs_data_q[i] !== longint'(px[i]) * px[i]) begin
        errors++; $display("FAIL bp_data[%0d]: got %0d required %0d", i, obs_data_q[i], longint'(px[i]) * px[i]);
      end
      $display("backpressure pixel=%0d out=%0d", px[i], obs_data_q[i]);
    end
  endtask

  task automatic test_clear();
    mode = 1'b1; out_ready = 1'b1;
    flush_queues();
    for (int i = 0; i < 7; i++) send_pixel(PIX_W'($urandom_range(0, 255)));
    pixel = PIX_W'($urandom_range(0, 255)); in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready: got %0b required 0", in_ready); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %0b required 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %0b required 0", out_valid); end
    for (int i = 0; i < ACC_N; i++) send_pixel(PIX_W'(3));
    in_valid = 1'b0;
    wait_drain();
    mode = 1'b0;
    checks++;
    if (obs_data_q.size() !== 1) begin
      errors++; $display("FAIL clr_count: got %0d outputs required 1", obs_data_q.size());
    end else begin
      checks++; if (obs_data_q[0] !== 64'd144) begin errors++; $display("FAIL clr_data: got %0d required 144", obs_data_q[0]); end
      $display("after clear 16x3 out=%0d", obs_data_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    longint sum = 0;
    int     v;
    mode = 1'b1; out_ready = 1'b0;
    flush_queues();
    for (int i = 0; i < ACC_N + 1; i++) send_pixel(PIX_W'($urandom_range(0, 255)));
    in_valid = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %0b required 1", out_valid); end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rm_out_data: got %0d required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rm_out_last: got %0b required 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %0b required 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %0b required 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    flush_queues();
    for (int i = 0; i < ACC_N; i++) begin
      v = int'($urandom_range(0, 255));
      sum += longint'(v) * v;
      send_pixel(PIX_W'(v));
    end
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (obs_data_q.size() !== 1) begin
      errors++; $display("FAIL rm_count: got %0d outputs required 1", obs_data_q.size());
    end else begin
      checks++; if (obs_data_q[0] !== sum) begin errors++; $display("FAIL rm_data: got %0d required %0d", obs_data_q[0], sum); end
      $display("after mid-window reset out=%0d", obs_data_q[0]);
    end
    mode = 1'b0;
  endtask

  task automatic test_mode_toggle();
    int     px[ACC_N + 4];
    longint expv[5];
    expv[0] = 0;
    for (int i = 0; i < ACC_N + 4; i++) begin
      px[i] = int'($urandom_range(0, 255));
      if (i < ACC_N) expv[0] += longint'(px[i]) * px[i];
      else expv[i - ACC_N + 1] = longint'(px[i]) * px[i];
    end
    mode = 1'b1; out_ready = 1'b1;
    flush_queues();
    for (int i = 0; i < ACC_N + 4; i++) begin
      if (i == 4) mode = 1'b0;
      send_pixel(PIX_W'(px[i]));
    end
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (obs_data_q.size() !== 5) begin errors++; $display("FAIL tg_count: got %0d outputs required 5", obs_data_q.size()); end
    for (int i = 0; i < 5 && i < obs_data_q.size(); i++) begin
      checks++; if (obs_data_q[i] !== expv[i]) begin errors++; $display("FAIL tg_data[%0d]: got %0d required %0d", i, obs_data_q[i], expv[i]); end
      checks++; if (obs_last_q[i] !== 1'b1) begin errors++; $display("FAIL tg_last[%0d]: got %0b required 1", i, obs_last_q[i]); end
      $display("mode toggle out[%0d]=%0d", i, obs_data_q[i]);
    end
  endtask

  task automatic test_random();
    int sent;
    int n;
    bit a;
    for (int seg = 0; seg < 4; seg++) begin
      mode = 1'($urandom_range(0, 1));
      flush_queues();
      sent = 0; n = 0;
      pixel = PIX_W'($urandom_range(0, 255));
      while (sent < 2 * ACC_N && n < 3000) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        a = in_valid && in_ready;
        @(posedge clk); #1;
        n++;
        if (a) begin sent++; pixel = PIX_W'($urandom_range(0, 255)); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      wait_drain();
      checks++;
      if (obs_data_q.size() !== exp_data_q.size()) begin
        errors++; $display("FAIL rnd%0d_count: got %0d outputs required %0d", seg, obs_data_q.size(), exp_data_q.size());
      end
      for (int i = 0; i < obs_data_q.size() && i < exp_data_q.size(); i++) begin
        checks++;
        if (obs_data_q[i] !== exp_data_q[i]) begin
          errors++; $display("FAIL rnd%0d_data[%0d]: got %0d required %0d", seg, i, obs_data_q[i], exp_data_q[i]);
        end
      end
      $display("random seg %0d mode=%0b outputs=%0d", seg, mode, obs_data_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_window_sum();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_mode_toggle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
